// File: rtl/stream_word_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_pack_pkg
//  Description : Shared defaults, lane helper and lane-count field type for
//                the stream word packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_pack_pkg;

    localparam int WORD_WIDTH_DEFAULT = 32;
    localparam int DATA_WIDTH_DEFAULT = 512;

    function automatic int lanes(input int dw, input int ww);
        return dw / ww;
    endfunction

    // Lane-count field for the default geometry (holds 1..N inclusive).
    typedef logic [$clog2(DATA_WIDTH_DEFAULT / WORD_WIDTH_DEFAULT):0] lane_count_t;

endpackage
`default_nettype wire

// File: rtl/stream_word_packer_beat_reg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_beat_reg
//  Description : One-entry avail/ready holding register for a packed beat
//                (data + last + count); a load replaces the entry on drain.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_beat_reg #(
    parameter int DATA_WIDTH  = 512,
    parameter int COUNT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [DATA_WIDTH-1:0]  load_data,
    input  logic                   load_last,
    input  logic [COUNT_WIDTH-1:0] load_count,
    input  logic                   out_ready,
    output logic                   out_avail,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last,
    output logic [COUNT_WIDTH-1:0] out_count
);

    logic                   r_avail;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_last;
    logic [COUNT_WIDTH-1:0] r_count;

    // The caller only loads when the slot is empty or draining this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_avail <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_count <= '0;
        end else if (load) begin
            r_avail <= 1'b1;
            r_data  <= load_data;
            r_last  <= load_last;
            r_count <= load_count;
        end else if (out_ready) begin
            r_avail <= 1'b0;
        end
    end

    assign out_avail = r_avail;
    assign out_data  = r_data;
    assign out_last  = r_last;
    assign out_count = r_count;

endmodule
`default_nettype wire

// File: rtl/stream_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : stream_word_packer
//  Description : Packs narrow host words into wide avail/ready beats; in_last
//                flushes a zero-padded partial beat.
//                Optional macro STREAM_PACK_BEAT_COUNT_EN adds beat_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_word_packer
    import stream_pack_pkg::*;
#(
    parameter int C_DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int C_WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    in_ready,
    input  logic                    in_avail,
    input  logic [C_WORD_WIDTH-1:0] in_data,
    input  logic                    in_last,
    input  logic                    out_ready,
    output logic                    out_avail,
    output logic [C_DATA_WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic [$clog2(lanes(C_DATA_WIDTH, C_WORD_WIDTH)):0] out_count
`ifdef STREAM_PACK_BEAT_COUNT_EN
    ,
    output logic [31:0]             beat_count
`endif
);

    localparam int c_LANES = lanes(C_DATA_WIDTH, C_WORD_WIDTH);
    localparam int c_IDX_W = $clog2(c_LANES);
    localparam int c_CNT_W = c_IDX_W + 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_LANES - 1);

    if (C_DATA_WIDTH % C_WORD_WIDTH != 0) begin : g_chk_ratio
        $error("stream_word_packer: C_DATA_WIDTH must be a multiple of C_WORD_WIDTH");
    end
    if (c_LANES < 2) begin : g_chk_lanes
        $error("stream_word_packer: at least two lanes are required");
    end

    logic [C_WORD_WIDTH-1:0] r_acc [c_LANES];
    logic [c_IDX_W-1:0]      r_idx;
    logic                    w_out_avail;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_complete;
    logic [C_DATA_WIDTH-1:0] w_beat;
    logic [c_CNT_W-1:0]      w_count;

    assign w_in_ready = !w_out_avail || out_ready;
    assign w_accept   = in_avail && w_in_ready;
    assign w_complete = w_accept && ((r_idx == c_LAST_IDX) || in_last);
    assign w_count    = {1'b0, r_idx} + c_CNT_W'(1);
    assign in_ready   = w_in_ready;
    assign out_avail  = w_out_avail;

    // Completed beat: stored lanes below idx, the incoming word at idx, zeros above.
    for (genvar k = 0; k < c_LANES; k++) begin : g_lane
        assign w_beat[k*C_WORD_WIDTH +: C_WORD_WIDTH] =
            (c_IDX_W'(k) == r_idx) ? in_data :
            (c_IDX_W'(k) <  r_idx) ? r_acc[k] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
            for (int k = 0; k < c_LANES; k++) r_acc[k] <= '0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_idx <= '0;
                for (int k = 0; k < c_LANES; k++) r_acc[k] <= '0;
            end else begin
                r_acc[r_idx] <= in_data;
                r_idx        <= r_idx + c_IDX_W'(1);
            end
        end
    end

    stream_beat_reg #(
        .DATA_WIDTH  (C_DATA_WIDTH),
        .COUNT_WIDTH (c_CNT_W)
    ) u_beat_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (w_complete),
        .load_data  (w_beat),
        .load_last  (in_last),
        .load_count (w_count),
        .out_ready  (out_ready),
        .out_avail  (w_out_avail),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_count  (out_count)
    );

`ifdef STREAM_PACK_BEAT_COUNT_EN
    logic [31:0] r_beat_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat_count <= '0;
        end else if (w_out_avail && out_ready) begin
            r_beat_count <= r_beat_count + 32'd1;
        end
    end

    assign beat_count = r_beat_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_word_packer
//  Description : Self-checking bench for stream_word_packer (128-bit beats,
//                32-bit words, 4 lanes) with a queue-based packing model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_word_packer;

    localparam int DW = 128;
    localparam int WW = 32;
    localparam int N  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_ready;
    logic          in_avail;
    logic [WW-1:0] in_data;
    logic          in_last;
    logic          out_ready;
    logic          out_avail;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [CW-1:0] out_count;
`ifdef STREAM_PACK_BEAT_COUNT_EN
    logic [31:0]   beat_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stream_word_packer #(
        .C_DATA_WIDTH (DW),
        .C_WORD_WIDTH (WW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_ready  (in_ready),
        .in_avail  (in_avail),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_ready (out_ready),
        .out_avail (out_avail),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_count (out_count)
`ifdef STREAM_PACK_BEAT_COUNT_EN
        ,
        .beat_count (beat_count)
`endif
    );

    // Reference: words fill lanes from 0 upward, everything above is zero.
    function automatic logic [DW-1:0] pack(input logic [WW-1:0] w[$]);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < w.size(); i++) r[i*WW +: WW] = w[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_avail = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_avail = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #2;
        n_tests++; if (out_avail !== 1'b0) begin n_fail++; $display("FAIL reset_avail: got %b expected 0", out_avail); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data); end
        n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", out_last); end
        n_tests++; if (out_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", out_count); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        tick();
    endtask

    task automatic test_full_beat();
        out_ready = 1'b1;
        for (int i = 1; i <= N; i++) begin
            in_avail = 1'b1; in_data = WW'(i); in_last = 1'b0;
            #1;
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_in_ready: got %b expected 1", in_ready); end
            tick();
        end
        in_avail = 1'b0;
        n_tests++; if (out_avail !== 1'b1) begin n_fail++; $display("FAIL full_avail: got %b expected 1", out_avail); end
        n_tests++; if (out_data !== 128'h00000004_00000003_00000002_00000001) begin n_fail++; $display("FAIL full_data: got %h expected 00000004000000030000000200000001", out_data); end
        n_tests++; if (out_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", out_count); end
        n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL full_last: got %b expected 0", out_last); end
        tick();
        n_tests++; if (out_avail !== 1'b0) begin n_fail++; $display("FAIL full_drain: got %b expected 0", out_avail); end
    endtask

    task automatic test_back_to_back();
        logic [WW-1:0] w[$];
        logic [WW-1:0] half[$];
        logic          exp_avail;
        out_ready = 1'b1;
        for (int i = 0; i < 2*N; i++) w.push_back($urandom);
        for (int i = 0; i < 2*N; i++) begin
            in_avail = 1'b1; in_data = w[i]; in_last = 1'b0;
            #1;
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: cycle %0d got %b expected 1", i, in_ready); end
            tick();
            exp_avail = (i % N) == N - 1;
            n_tests++; if (out_avail !== exp_avail) begin n_fail++; $display("FAIL b2b_avail: cycle %0d got %b expected %b", i, out_avail, exp_avail); end
            if (exp_avail) begin
                half = w[i-N+1 : i];
                n_tests++; if (out_data !== pack(half)) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", out_data, pack(half)); end
                n_tests++; if (out_count !== 3'd4) begin n_fail++; $display("FAIL b2b_count: got %0d expected 4", out_count); end
            end
        end
        in_avail = 1'b0;
        tick();
    endtask

    task automatic test_last();
        logic [WW-1:0] w[$];
        out_ready = 1'b1;
        w.push_back($urandom); w.push_back($urandom);
        in_avail = 1'b1; in_data = w[0]; in_last = 1'b0; tick();
        in_data = w[1]; in_last = 1'b1; tick();
        in_avail = 1'b0; in_last = 1'b0;
        n_tests++; if (out_data !== pack(w)) begin n_fail++; $display("FAIL last2_data: got %h expected %h", out_data, pack(w)); end
        n_tests++; if (out_count !== 3'd2) begin n_fail++; $display("FAIL last2_count: got %0d expected 2", out_count); end
        n_tests++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL last2_last: got %b expected 1", out_last); end
        // Next word lands in lane 0; its beat replaces the draining one with no bubble.
        w.delete(); w.push_back($urandom);
        in_avail = 1'b1; in_data = w[0]; in_last = 1'b1; tick();
        in_avail = 1'b0; in_last = 1'b0;
        n_tests++; if (out_avail !== 1'b1) begin n_fail++; $display("FAIL last1_avail: got %b expected 1", out_avail); end
        n_tests++; if (out_data !== pack(w)) begin n_fail++; $display("FAIL last1_data: got %h expected %h", out_data, pack(w)); end
        n_tests++; if (out_count !== 3'd1) begin n_fail++; $display("FAIL last1_count: got %0d expected 1", out_count); end
        w.delete();
        for (int i = 0; i < N; i++) begin
            w.push_back($urandom);
            in_avail = 1'b1; in_data = w[i]; in_last = (i == N - 1); tick();
        end
        in_avail = 1'b0; in_last = 1'b0;
        n_tests++; if (out_data !== pack(w)) begin n_fail++; $display("FAIL last4_data: got %h expected %h", out_data, pack(w)); end
        n_tests++; if (out_count !== 3'd4) begin n_fail++; $display("FAIL last4_count: got %0d expected 4", out_count); end
        n_tests++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL last4_last: got %b expected 1", out_last); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [WW-1:0] w[$];
        logic [WW-1:0] v[$];
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            w.push_back($urandom);
            in_avail = 1'b1; in_data = w[i]; in_last = 1'b0; tick();
        end
        v.push_back($urandom);
        in_avail = 1'b1; in_data = v[0];
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++; if (out_avail !== 1'b1) begin n_fail++; $display("FAIL bp_hold_avail: got %b expected 1", out_avail); end
            n_tests++; if (out_data !== pack(w)) begin n_fail++; $display("FAIL bp_hold_data: got %h expected %h", out_data, pack(w)); end
        end
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_high: got %b expected 1", in_ready); end
        tick();
        n_tests++; if (out_avail !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", out_avail); end
        for (int i = 1; i < N; i++) begin
            v.push_back($urandom);
            in_data = v[i]; tick();
        end
        in_avail = 1'b0;
        n_tests++; if (out_data !== pack(v)) begin n_fail++; $display("FAIL bp_next_data: got %h expected %h", out_data, pack(v)); end
        tick();
    endtask

    task automatic test_reset_midburst();
        logic [WW-1:0] w[$];
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_avail = 1'b1; in_data = $urandom; in_last = 1'b0; tick();
        end
        in_avail = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_tests++; if (out_avail !== 1'b0) begin n_fail++; $display("FAIL rst_pending_avail: got %b expected 0", out_avail); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_pending_data: got %h expected 0", out_data); end
        @(negedge clk) reset = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_avail = 1'b1; in_data = $urandom; tick();
        end
        in_avail = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_tests++; if (out_avail !== 1'b0) begin n_fail++; $display("FAIL rst_partial_avail: got %b expected 0", out_avail); end
        @(negedge clk) reset = 1'b0;
        tick();
        for (int i = 0; i < N; i++) begin
            w.push_back($urandom);
            in_avail = 1'b1; in_data = w[i]; tick();
            if (i < N - 1) begin
                n_tests++; if (out_avail !== 1'b0) begin n_fail++; $display("FAIL rst_stale_early: word %0d got %b expected 0", i, out_avail); end
            end
        end
        in_avail = 1'b0;
        n_tests++; if (out_data !== pack(w)) begin n_fail++; $display("FAIL rst_fresh_data: got %h expected %h", out_data, pack(w)); end
        n_tests++; if (out_count !== 3'd4) begin n_fail++; $display("FAIL rst_fresh_count: got %0d expected 4", out_count); end
        tick();
    endtask

    task automatic test_random();
        logic [WW-1:0] cur[$];
        logic          m_avail;
        logic [DW-1:0] m_data;
        logic          m_last;
        logic [CW-1:0] m_count;
        logic          exp_ready;
        do_reset();
        m_avail = 1'b0; m_data = '0; m_last = 1'b0; m_count = '0;
        for (int c = 0; c < 400; c++) begin
            n_tests++; if (out_avail !== m_avail) begin n_fail++; $display("FAIL rnd_avail: cycle %0d got %b expected %b", c, out_avail, m_avail); end
            if (m_avail) begin
                n_tests++; if (out_data !== m_data) begin n_fail++; $display("FAIL rnd_data: cycle %0d got %h expected %h", c, out_data, m_data); end
                n_tests++; if (out_count !== m_count || out_last !== m_last) begin n_fail++; $display("FAIL rnd_meta: cycle %0d got count %0d last %b expected count %0d last %b", c, out_count, out_last, m_count, m_last); end
            end
            in_avail  = $urandom_range(0, 3) != 0;
            in_data   = $urandom;
            in_last   = $urandom_range(0, 4) == 0;
            out_ready = $urandom_range(0, 2) != 0;
            exp_ready = !m_avail || out_ready;
            #1;
            n_tests++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready: cycle %0d got %b expected %b", c, in_ready, exp_ready); end
            if (in_avail && exp_ready) begin
                cur.push_back(in_data);
                if (cur.size() == N || in_last) begin
                    m_data = pack(cur); m_count = CW'(cur.size()); m_last = in_last; m_avail = 1'b1;
                    cur.delete();
                end else if (out_ready) begin
                    m_avail = 1'b0;
                end
            end else if (out_ready) begin
                m_avail = 1'b0;
            end
            tick();
        end
        in_avail = 1'b0; in_last = 1'b0;
    endtask

`ifdef STREAM_PACK_BEAT_COUNT_EN
    task automatic test_beat_count();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3*N; i++) begin
            in_avail = 1'b1; in_data = $urandom; in_last = 1'b0; tick();
        end
        in_avail = 1'b0;
        tick();
        n_tests++; if (beat_count !== 32'd3) begin n_fail++; $display("FAIL beat_count_3: got %0d expected 3", beat_count); end
        force dut.r_beat_count = 32'hFFFF_FFFF;
        #1 release dut.r_beat_count;
        for (int i = 0; i < N; i++) begin
            in_avail = 1'b1; in_data = $urandom; tick();
        end
        in_avail = 1'b0;
        tick();
        n_tests++; if (beat_count !== 32'd0) begin n_fail++; $display("FAIL beat_count_wrap: got %h expected 0", beat_count); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_beat();
        test_back_to_back();
        test_last();
        test_backpressure();
        test_reset_midburst();
        test_random();
`ifdef STREAM_PACK_BEAT_COUNT_EN
        test_beat_count();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
